conv55_window_feeder: RTL and testbench
=======================================

# conv55_window_feeder

Streaming 5×5 window generator that converts a raster-order 8-bit pixel stream into the 25 packed pixel operands that the 5×5 convolution CLB consumes. Four line buffers and a 5×5 register window are shifted once per accepted pixel. One window is emitted per valid (unpadded, stride-1) convolution position. Sits between the feature-map source and the conv55 multiply/adder-tree datapath in the LeNet-5 PIM flow.

## Interface
- `IMG_W`, default 32: square feature-map width and height in pixels; legal range 5..1024.
- `DATA_W`, default 8: pixel width in bits. The conv55 datapath requires 8.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_pixel` carries a valid pixel.
- `in_ready` output 1: the feeder can accept a pixel this cycle.
- `in_pixel` input DATA_W: pixel, raster order (row-major, top-left first).
- `win_valid` output 1: `win_data` holds a complete window.
- `win_ready` input 1: the downstream datapath takes the window this cycle.
- `win_data` output 25*DATA_W: packed window; element k = r*5+c sits at bits [DATA_W*k+DATA_W-1 : DATA_W*k], with r = 0 the top (oldest) row and c = 0 the leftmost column.
- `frame_done` output 1: single-cycle pulse, the last pixel of a frame was accepted.
- `win_count` output 16: present only with `CONV55_WIN_COUNT_EN`; see Configuration.

## Operation
- Accept condition: `in_valid && in_ready`. Transfer condition: `win_valid && win_ready`.
- `in_ready = !win_valid || win_ready`. This is combinational and allows full throughput of one pixel per cycle.
- Counters `col` and `row` each run 0..IMG_W-1.
  - On accept, `col` increments.
  - At IMG_W-1, `col` wraps to 0 and `row` increments.
  - At row IMG_W-1 and col IMG_W-1, both wrap to 0 and `frame_done` pulses.
- Line buffers: four IMG_W-deep delay lines, which may be shift registers or RAM. Each delay line shifts only on accept.
- The window shift register takes a new right-hand column each accept: {linebuf3_out, linebuf2_out, linebuf1_out, linebuf0_out, in_pixel}, top to bottom.
- A window is emitted when the accepted pixel has row ≥ 4 and col ≥ 4. That pixel (R,C) becomes element 24. In general, element r*5+c equals pixel(R-4+r, C-4+c).
- Windows per frame: (IMG_W-4)². This is 784 for IMG_W = 32.
- No window is emitted for col 0..3 of any row, or for rows 0..3. Line-buffer contents from the previous row and frame are overwritten before use, so no flush is needed between frames.
- Arithmetic: counters are clog2(IMG_W) bits wide and compare against IMG_W-1 for wrap. No pixel arithmetic.

## Timing
- Reset values: `win_valid` = 0, `win_data` = 0, `frame_done` = 0, `win_count` = 0, and `col` = `row` = 0.
  - `in_ready` = 1 during and after reset.
  - Line-buffer contents are don't-care.
- Latency: the window completed by the pixel accepted in cycle t shows `win_valid` = 1 in cycle t+1.
- Stall: while `win_valid && !win_ready`, `win_data` and `win_valid` hold, and `in_ready` = 0, so no pixel is accepted.
- Simultaneous transfer and accept in the same cycle:
  - If the accepted pixel completes a window, `win_data` reloads and `win_valid` stays 1.
  - Otherwise `win_valid` falls to 0.
- `frame_done` is asserted in the cycle after the last pixel is accepted, coincident with `win_valid` for the final window.
- Reset mid-frame, asynchronously:
  - Counters clear and `win_valid` drops immediately.
  - Any pending window is discarded.
  - The next accepted pixel is treated as (0,0).

## Configuration
- `CONV55_WIN_COUNT_EN` defined:
  - Adds the `win_count` output port, a 16-bit count of windows transferred in the current frame.
  - It increments on each transfer.
  - It clears on reset, and on the cycle after the frame's final window is transferred.
- `CONV55_WIN_COUNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Ramp, IMG_W = 32, pixel = (row*32+col) & 0xFF, `win_ready` tied 1:
  - The first `win_valid` appears 1 cycle after accepting pixel index 132. Element 0 = 0, element 4 = 4, element 20 = 128, element 24 = 132.
  - Exactly 784 windows per frame.
  - `frame_done` pulses once, after pixel 1023.
- Row boundary: accepting pixels (5,0)..(5,3) produces no window. Pixel (5,4) produces a window with element 0 = pixel(1,0) = 32 and element 24 = (164) & 0xFF = 164.
- Backpressure: hold `win_ready` = 0 for 10 cycles after the first window. `in_ready` = 0 and `win_data` is bit-stable throughout. Releasing it resumes with no window lost or duplicated, verified against a reference count of 784.
- Back-to-back frames with continuous `in_valid`:
  - The second frame's first window equals the first frame's first window.
  - There are no spurious windows across the frame seam.
  - With `CONV55_WIN_COUNT_EN`, `win_count` reaches 784 and then restarts at 0.
- Reset at pixel 500 with a window pending: `win_valid` = 0 immediately. After release, a full frame yields 784 correct windows.
- Random `in_valid`/`win_ready` (50% each) over 3 frames: the scoreboard matches the golden window sequence, and `in_ready` never rises while a stalled window is held.

Source files
------------

// File: rtl/conv55_window_feeder.sv
// rtl/conv55_window_feeder.sv - 5x5 sliding-window generator for the conv55 datapath (optional win_count via CONV55_WIN_COUNT_EN)
module conv55_window_feeder #(
    parameter int IMG_W  = 32,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_pixel,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [25*DATA_W-1:0]   win_data,
    output logic                   frame_done
`ifdef CONV55_WIN_COUNT_EN
    ,
    output logic [15:0]            win_count
`endif
);

    localparam int              CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CW-1:0]   LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0]   FOUR = CW'(4);

    logic [CW-1:0]          col_q, col_d, row_q, row_d;
    logic                   win_valid_q, win_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic [25*DATA_W-1:0]   win_q, win_d;
    logic [DATA_W-1:0]      lb_q [4][IMG_W];
    logic [DATA_W-1:0]      lb_d [4][IMG_W];
    logic                   accept, xfer, win_hit;

    assign in_ready   = !win_valid_q || win_ready;
    assign accept     = in_valid && in_ready;
    assign xfer       = win_valid_q && win_ready;
    assign win_hit    = accept && (row_q >= FOUR) && (col_q >= FOUR);
    assign win_valid  = win_valid_q;
    assign win_data   = win_q;
    assign frame_done = frame_done_q;

    // Chained delay lines: each one outputs the pixel one row above its input.
    always_comb begin
        lb_d = lb_q;
        if (accept) begin
            lb_d[0][0] = in_pixel;
            for (int i = 1; i < 4; i++) lb_d[i][0] = lb_q[i-1][IMG_W-1];
            for (int i = 0; i < 4; i++)
                for (int k = 1; k < IMG_W; k++) lb_d[i][k] = lb_q[i][k-1];
        end
    end

    // Window shifts left; the new right column is oldest row (top) to in_pixel (bottom).
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 4; c++)
                    win_d[DATA_W*(r*5+c) +: DATA_W] = win_q[DATA_W*(r*5+c+1) +: DATA_W];
            for (int r = 0; r < 4; r++)
                win_d[DATA_W*(r*5+4) +: DATA_W] = lb_q[3-r][IMG_W-1];
            win_d[DATA_W*24 +: DATA_W] = in_pixel;
        end
    end

    // Raster position, frame end pulse and window-valid handshake.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        win_valid_d  = win_valid_q;
        if (accept) begin
            if (col_q == LAST) begin
                col_d = '0;
                if (row_q == LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + CW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        if (win_hit)
            win_valid_d = 1'b1;
        else if (xfer)
            win_valid_d = 1'b0;
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_q        <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    // Line-buffer storage needs no reset: stale rows are overwritten before use.
    always_ff @(posedge clk) begin
        lb_q <= lb_d;
    end

`ifdef CONV55_WIN_COUNT_EN
    logic [15:0] win_count_q, win_count_d;
    logic        last_pend_q, last_pend_d;
    logic        wc_clr_q, wc_clr_d;

    assign win_count = win_count_q;

    // last_pend marks the held window as the frame's final one; its transfer clears the count next cycle.
    always_comb begin
        last_pend_d = last_pend_q;
        if (frame_done_d)
            last_pend_d = 1'b1;
        else if (xfer)
            last_pend_d = 1'b0;
        wc_clr_d    = xfer && last_pend_q;
        win_count_d = (wc_clr_q ? 16'd0 : win_count_q) + {15'd0, xfer};
    end

    // Window counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_count_q <= '0;
            last_pend_q <= 1'b0;
            wc_clr_q    <= 1'b0;
        end else begin
            win_count_q <= win_count_d;
            last_pend_q <= last_pend_d;
            wc_clr_q    <= wc_clr_d;
        end
    end
`endif

endmodule

// File: tb/tb_conv55_window_feeder.sv
// tb/tb_conv55_window_feeder.sv - scoreboard bench for conv55_window_feeder
module tb_conv55_window_feeder;

    localparam int W     = 32;
    localparam int NWIN  = (W - 4) * (W - 4);
    localparam int LIMIT = 60000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_pixel;
    logic         win_valid;
    logic         win_ready;
    logic [199:0] win_data;
    logic         frame_done;
`ifdef CONV55_WIN_COUNT_EN
    logic [15:0]  win_count;
`endif

    conv55_window_feeder #(.IMG_W(W), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .frame_done (frame_done)
`ifdef CONV55_WIN_COUNT_EN
        ,
        .win_count  (win_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [199:0] data;
        int           idx;
        bit           ramp;
        bit           last;
    } ent_t;

    ent_t       q[$];
    logic [7:0] img [W][W];
    int         n_total = 0;
    int         n_bad   = 0;
    int         cycles  = 0;
    int         mr = 0, mc = 0;
    int         xfer_cnt = 0;
    int         frames_out = 0;
    int         bp_left = 0;
    bit         bp_arm = 0;
    bit         rand_pix = 0;
    bit         fd_exp = 0;
    int         wc_m = 0;
    bit         wc_clr = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int pv, input int pr);
        logic         acc, xfer;
        logic [199:0] w;
        ent_t         e;
        @(negedge clk);
        in_valid = ($urandom_range(99) < pv);
        if (bp_left > 0) begin
            win_ready = 1'b0;
            bp_left--;
        end else begin
            win_ready = ($urandom_range(99) < pr);
        end
        in_pixel = rand_pix ? 8'($urandom) : 8'((mr * W + mc) & 255);
        #1;
        cycles++;
        chk("win_valid", {255'd0, win_valid}, {255'd0, q.size() != 0});
        chk("in_ready", {255'd0, in_ready}, {255'd0, (q.size() == 0) || win_ready});
        chk("frame_done", {255'd0, frame_done}, {255'd0, fd_exp});
`ifdef CONV55_WIN_COUNT_EN
        chk("win_count", {240'd0, win_count}, 256'(wc_m));
`endif
        if (q.size() != 0) chk("win_data", {56'd0, win_data}, {56'd0, q[0].data});
        acc  = in_valid && ((q.size() == 0) || win_ready);
        xfer = (q.size() != 0) && win_ready;
        wc_m = (wc_clr ? 0 : wc_m) + (xfer ? 1 : 0);
        wc_clr = 0;
        if (xfer) begin
            e = q.pop_front();
            xfer_cnt++;
            if (e.ramp && e.idx == 0) begin
                chk("first_e0", {248'd0, e.data[7:0]}, 256'd0);
                chk("first_e4", {248'd0, e.data[39:32]}, 256'd4);
                chk("first_e20", {248'd0, e.data[167:160]}, 256'd128);
                chk("first_e24", {248'd0, e.data[199:192]}, 256'd132);
            end
            if (e.ramp && e.idx == W - 4) begin
                chk("row5_e0", {248'd0, e.data[7:0]}, 256'd32);
                chk("row5_e24", {248'd0, e.data[199:192]}, 256'd164);
            end
            if (e.last) begin
                chk("win_per_frame", 256'(xfer_cnt), 256'(NWIN));
                xfer_cnt = 0;
                frames_out++;
                wc_clr = 1;
            end
        end
        fd_exp = 0;
        if (acc) begin
            img[mr][mc] = in_pixel;
            if (mr >= 4 && mc >= 4) begin
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++)
                        w[8*(r*5+c) +: 8] = img[mr-4+r][mc-4+c];
                e.data = w;
                e.idx  = (mr - 4) * (W - 4) + (mc - 4);
                e.ramp = !rand_pix;
                e.last = (mr == W - 1) && (mc == W - 1);
                q.push_back(e);
                if (bp_arm) begin
                    bp_arm  = 0;
                    bp_left = 10;
                end
            end
            if (mr == W - 1 && mc == W - 1) fd_exp = 1;
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == W - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
    endtask

    task automatic run_frames(input int n, input int pv, input int pr);
        int target;
        target = frames_out + n;
        while (frames_out < target && cycles < LIMIT) step(pv, pr);
        if (cycles >= LIMIT) chk("timeout", 256'(frames_out), 256'(target));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        win_ready = 1'b0;
        in_pixel = 8'd0;
        @(negedge clk);
        #1;
        chk("rst_win_valid", {255'd0, win_valid}, 256'd0);
        chk("rst_win_data", {56'd0, win_data}, 256'd0);
        chk("rst_in_ready", {255'd0, in_ready}, 256'd1);
        chk("rst_frame_done", {255'd0, frame_done}, 256'd0);
`ifdef CONV55_WIN_COUNT_EN
        chk("rst_win_count", {240'd0, win_count}, 256'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_frames(1, 100, 100);
        bp_arm = 1;
        run_frames(1, 100, 100);

        while (!(mr == 15 && mc == 21) && cycles < LIMIT) step(100, 100);
        @(negedge clk);
        in_valid = 1'b0;
        win_ready = 1'b0;
        #1;
        chk("pending_pre_rst", {255'd0, win_valid}, 256'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_win_valid", {255'd0, win_valid}, 256'd0);
        chk("mid_rst_in_ready", {255'd0, in_ready}, 256'd1);
        q.delete();
        mr = 0;
        mc = 0;
        xfer_cnt = 0;
        fd_exp = 0;
        wc_m = 0;
        wc_clr = 0;
        @(negedge clk);
        rst = 1'b0;
        run_frames(1, 100, 100);

        rand_pix = 1;
        run_frames(3, 50, 50);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
